// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared Mini-MIPS encodings for the multiply/divide path.
// Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam logic [2:0] MUL_OP_NOP   = 3'd0;
    localparam logic [2:0] MUL_OP_MULT  = 3'd1;
    localparam logic [2:0] MUL_OP_MULTU = 3'd2;
    localparam logic [2:0] MUL_OP_MADD  = 3'd3;
    localparam logic [2:0] MUL_OP_MADDU = 3'd4;
    localparam logic [2:0] MUL_OP_DIV   = 3'd5;
    localparam logic [2:0] MUL_OP_DIVU  = 3'd6;
    localparam logic [2:0] MUL_OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_t;

    function automatic logic is_valid_op(input logic [2:0] op);
        return (op != MUL_OP_NOP) && (op != MUL_OP_RSVD);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MUL_OP_DIV) || (op == MUL_OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MUL_OP_MULT) || (op == MUL_OP_MADD) || (op == MUL_OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_negate.sv
`default_nettype none
// ============================================================================
// Module      : cond_negate
// Description : Two's-complement negation when neg is set, pass-through else.
// Revision    : 1.0  initial release
// ============================================================================
module cond_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] in,
    input  logic         neg,
    output logic [W-1:0] out
);

    assign out = neg ? (~in + W'(1)) : in;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 multiply/divide unit with HI/LO registers.
// Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       mul_op,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic             abort,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    muldiv_state_t      r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_p, r_q, r_m;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic               r_neg_res, r_neg_rem;

    logic               w_accept, w_is_div, w_div_by_zero, w_sign_a, w_sign_b, w_run_div;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem;
    logic [WIDTH:0]     w_add_a, w_add_b, w_mul_step;
    logic [WIDTH+1:0]   w_sum;
    logic [2*WIDTH-1:0] w_prod, w_result;

    assign w_accept      = (r_state == ST_IDLE) && is_valid_op(mul_op) && !abort;
    assign w_is_div      = is_div_op(mul_op);
    assign w_div_by_zero = w_is_div && (in2 == '0);
    assign w_sign_a      = is_signed_op(mul_op) && in1[WIDTH-1];
    assign w_sign_b      = is_signed_op(mul_op) && in2[WIDTH-1];

    cond_negate #(.W(WIDTH)) u_mag_a (.in(in1), .neg(w_sign_a), .out(w_mag_a));
    cond_negate #(.W(WIDTH)) u_mag_b (.in(in2), .neg(w_sign_b), .out(w_mag_b));

    // Shared adder: shift-add for multiply, trial subtract (carry-out = no borrow) for divide
    assign w_run_div  = is_div_op(r_op);
    assign w_add_a    = w_run_div ? {r_p, r_q[WIDTH-1]} : {1'b0, r_p};
    assign w_add_b    = w_run_div ? ~{1'b0, r_m} : {1'b0, r_m};
    assign w_sum      = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(WIDTH+1){1'b0}}, w_run_div};
    assign w_mul_step = r_q[0] ? w_sum[WIDTH:0] : {1'b0, r_p};

    cond_negate #(.W(2*WIDTH)) u_fix_prod (.in({r_p, r_q}), .neg(r_neg_res), .out(w_prod));
    cond_negate #(.W(WIDTH))   u_fix_quo  (.in(r_q),        .neg(r_neg_res), .out(w_quo));
    cond_negate #(.W(WIDTH))   u_fix_rem  (.in(r_p),        .neg(r_neg_rem), .out(w_rem));

    always_comb begin
        w_result = w_prod;
        case (r_op)
            MUL_OP_MADD, MUL_OP_MADDU: w_result = {hi, lo} + w_prod;
            MUL_OP_DIV, MUL_OP_DIVU:   w_result = {w_rem, w_quo};
            default:                   w_result = w_prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = w_div_by_zero ? ST_FIX : ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort)              w_state_nxt = ST_IDLE;
                else if (r_cnt == '0)   w_state_nxt = ST_FIX;
            end
            ST_FIX: begin
                busy        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            r_p       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_op      <= MUL_OP_NOP;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= mul_op;
                        r_p       <= '0;
                        r_q       <= w_is_div ? w_mag_a : w_mag_b;
                        r_m       <= w_is_div ? w_mag_b : w_mag_a;
                        r_cnt     <= CNT_W'(WIDTH - 1);
                        r_neg_res <= w_sign_a ^ w_sign_b;
                        r_neg_rem <= w_sign_a;
                        div_zero  <= w_div_by_zero;
                    end else begin
                        if (hi_wr) hi <= in1;
                        if (lo_wr) lo <= in1;
                    end
                end
                ST_RUN: begin
                    if (!abort) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_run_div) begin
                            if (w_sum[WIDTH+1]) r_p <= w_sum[WIDTH-1:0];
                            else                r_p <= {r_p[WIDTH-2:0], r_q[WIDTH-1]};
                            r_q <= {r_q[WIDTH-2:0], w_sum[WIDTH+1]};
                        end else begin
                            r_p <= w_mul_step[WIDTH:1];
                            r_q <= {w_mul_step[0], r_q[WIDTH-1:1]};
                        end
                    end
                end
                ST_FIX: begin
                    if (!abort) begin
                        done <= 1'b1;
                        // A zero divisor leaves HI/LO untouched; only the flag reports it
                        if (!div_zero) {hi, lo} <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
